// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared FSM encoding and width helper for the multiplier arbiter
package mult_arb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/mult_array.sv
// mult_array: combinational unsigned array multiplier built from shifted partial products
module mult_array #(
  parameter int W = 4
) (
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_z
);
  // accumulate one partial-product row per bit of i_b
  always_comb begin
    o_z = '0;
    for (int i = 0; i < W; i++) o_z = o_z + ({{W{1'b0}}, i_a & {W{i_b[i]}}} << i);
  end
endmodule

// File: rtl/mult_arb_ctrl.sv
// mult_arb_ctrl: round-robin sharing of one array multiplier among requesters
module mult_arb_ctrl
  import mult_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_REQ = 4,
  parameter int MULT_LAT = 1,
  localparam int ID_W = clog2(NUM_REQ),
  localparam int CW = clog2(MULT_LAT + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_b,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [2*DATA_WIDTH-1:0]          rsp_z,
  output logic [ID_W-1:0]                  rsp_id,
  output logic                             busy
);
  localparam logic [CW-1:0] LAST = CW'(MULT_LAT - 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  state_t r_state, w_next;
  logic [ID_W-1:0] r_last, r_id, w_grant;
  logic [CW-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_a, r_b;
  logic [2*DATA_WIDTH-1:0] w_z;
  logic [ID_W-1:0] w_idx [NUM_REQ];
  logic [NUM_REQ-1:0] w_hit;
  logic w_any, w_done, w_take;
  assign w_any = |req_valid;
  assign w_take = r_state == IDLE && w_any;
  assign w_done = r_cnt == LAST;
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_rr
    assign w_idx[k] = ID_W'((int'(r_last) + 1 + k) % NUM_REQ);
    assign w_hit[k] = req_valid[w_idx[k]];
  end
  // first hit in rotated order, starting just after the last grant
  always_comb begin
    w_grant = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) if (w_hit[k]) w_grant = w_idx[k];
  end
  // next state and handshake outputs
  always_comb begin
    w_next = r_state;
    if (w_take) w_next = CALC;
    if (r_state == CALC && w_done) w_next = RESP;
    if (r_state == RESP && rsp_ready) w_next = IDLE;
    req_ready = w_take ? ONE << w_grant : '0;
    rsp_valid = r_state == RESP;
    busy = r_state != IDLE;
  end
  // state register
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  // operand latch on accept, multicycle count, product capture on last CALC edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= ID_W'(NUM_REQ - 1);
      r_cnt <= '0;
      r_a <= '0;
      r_b <= '0;
      r_id <= '0;
      rsp_z <= '0;
      rsp_id <= '0;
    end else begin
      if (w_take) begin
        r_a <= req_a[w_grant*DATA_WIDTH +: DATA_WIDTH];
        r_b <= req_b[w_grant*DATA_WIDTH +: DATA_WIDTH];
        r_id <= w_grant;
        r_last <= w_grant;
        r_cnt <= '0;
      end
      if (r_state == CALC) begin
        r_cnt <= w_done ? '0 : r_cnt + CW'(1);
        if (w_done) begin
          rsp_z <= w_z;
          rsp_id <= r_id;
        end
      end
    end
  end
  mult_array #(.W(DATA_WIDTH)) u_mul (.i_a(r_a), .i_b(r_b), .o_z(w_z));
endmodule

// File: tb/tb_mult_arb_ctrl.sv
// tb_mult_arb_ctrl: scoreboard bench driving two controllers (latency 1 and 3) from shared requesters
module tb_mult_arb_ctrl;
  typedef struct {
    int id;
    int z;
  } exp_t;
  logic clk = 0, rst;
  logic [3:0] req_valid;
  logic [15:0] req_a, req_b;
  logic rsp_ready;
  logic [3:0] rdy0, rdy1;
  logic rv0, rv1, bz0, bz1;
  logic [7:0] z0, z1;
  logic [1:0] id0, id1;
  int total = 0, bad = 0;
  int m_st[2], m_cnt[2], m_last[2];
  exp_t q0[$], q1[$];
  always #5 clk = ~clk;
  mult_arb_ctrl #(.DATA_WIDTH(4), .NUM_REQ(4), .MULT_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy0), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_z(z0), .rsp_id(id0), .busy(bz0));
  mult_arb_ctrl #(.DATA_WIDTH(4), .NUM_REQ(4), .MULT_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_z(z1), .rsp_id(id1), .busy(bz1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask
  // one negedge of the transaction-level model for controller d
  task automatic step(input int d, input int lat, input logic [3:0] rdy, input logic rv,
                      input logic bz, input logic [7:0] z, input logic [1:0] id);
    logic [3:0] er;
    int g, qs;
    exp_t e;
    er = '0;
    g = -1;
    if (m_st[d] == 0)
      for (int k = 1; k <= 4; k++) begin
        int i;
        i = (m_last[d] + k) % 4;
        if (g < 0 && req_valid[i]) g = i;
      end
    if (g >= 0) er[g] = 1'b1;
    chk($sformatf("ready%0d", d), rdy, er);
    chk($sformatf("rsp_valid%0d", d), rv, m_st[d] == 2);
    chk($sformatf("busy%0d", d), bz, m_st[d] != 0);
    if (rv && m_st[d] == 2) begin
      qs = d == 0 ? q0.size() : q1.size();
      chk($sformatf("sb_size%0d", d), qs, 1);
      if (qs > 0) begin
        e = d == 0 ? q0[0] : q1[0];
        chk($sformatf("rsp_z%0d", d), z, e.z);
        chk($sformatf("rsp_id%0d", d), id, e.id);
        if (rsp_ready) begin
          if (d == 0) void'(q0.pop_front());
          else void'(q1.pop_front());
        end
      end
    end
    case (m_st[d])
      0: if (g >= 0) begin
        e.id = g;
        e.z = int'(req_a[g*4 +: 4]) * int'(req_b[g*4 +: 4]);
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
        m_last[d] = g;
        m_st[d] = 1;
        m_cnt[d] = 0;
      end
      1: if (m_cnt[d] == lat - 1) m_st[d] = 2; else m_cnt[d]++;
      default: if (rsp_ready) m_st[d] = 0;
    endcase
  endtask
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_st[d] = 0;
        m_cnt[d] = 0;
        m_last[d] = 3;
      end
      q0.delete();
      q1.delete();
    end else begin
      step(0, 1, rdy0, rv0, bz0, z0, id0);
      step(1, 3, rdy1, rv1, bz1, z1, id1);
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic put(input int i, input logic [3:0] a, input logic [3:0] b);
    req_a[i*4 +: 4] = a;
    req_b[i*4 +: 4] = b;
  endtask
  initial begin
    rst = 1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1;
    cyc(2);
    rst = 0;
    cyc(2);
    put(2, 15, 15);
    req_valid = 4'b0100;
    cyc(1);
    req_valid = '0;
    cyc(8);
    for (int i = 0; i < 4; i++) put(i, 4'(i + 1), 3);
    req_valid = 4'hF;
    cyc(20);
    req_valid = '0;
    cyc(8);
    put(0, 5, 6);
    put(1, 7, 11);
    rsp_ready = 0;
    req_valid = 4'b0011;
    cyc(10);
    rsp_ready = 1;
    cyc(6);
    req_valid = '0;
    cyc(8);
    put(0, 9, 7);
    req_valid = 4'b0001;
    cyc(1);
    req_valid = '0;
    put(0, 15, 15);
    cyc(8);
    put(2, 13, 11);
    req_valid = 4'b0100;
    cyc(1);
    req_valid = '0;
    rst = 1;
    cyc(1);
    rst = 0;
    cyc(6);
    put(1, 3, 4);
    put(3, 5, 5);
    req_valid = 4'b1010;
    cyc(1);
    req_valid = 4'b1000;
    cyc(6);
    req_valid = '0;
    cyc(8);
    put(0, 0, 15);
    req_valid = 4'b0001;
    cyc(1);
    req_valid = '0;
    cyc(8);
    put(3, 8, 8);
    req_valid = 4'b1000;
    cyc(1);
    req_valid = '0;
    cyc(8);
    for (int c = 0; c < 1000; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_a = 16'($urandom);
      req_b = 16'($urandom);
      rsp_ready = $urandom_range(0, 3) != 0;
      cyc(1);
    end
    req_valid = '0;
    rsp_ready = 1;
    cyc(20);
    chk("drain0", q0.size(), 0);
    chk("drain1", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_arb_ctrl.md
# mult_arb_ctrl

Round-robin arbiter and sequencer that shares one combinational array multiplier among `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The controller grants one requester at a time, holds the operands stable for a configurable multicycle window, registers the product, and returns it tagged with the requester ID. It sits between client datapaths and a single multiplier instance, so the multiplier area is paid only once.

## Interface

Parameters:
- `DATA_WIDTH`, 4: operand width; the product is `2*DATA_WIDTH` bits.
- `NUM_REQ`, 4: number of requesters; must be at least 2.
- `MULT_LAT`, 1: number of cycles the multiplier inputs are held before the product is captured; must be at least 1.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req_valid`, input, `NUM_REQ`: per-requester request valid.
- `req_ready`, output, `NUM_REQ`: per-requester accept; at most one bit is high in any cycle.
- `req_a`, input, `NUM_REQ*DATA_WIDTH`: packed operand A; requester i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_b`, input, `NUM_REQ*DATA_WIDTH`: packed operand B, same packing as `req_a`.
- `rsp_valid`, output, 1: response valid.
- `rsp_ready`, input, 1: downstream accepts the response.
- `rsp_z`, output, `2*DATA_WIDTH`: unsigned product A*B.
- `rsp_id`, output, `ID_W`: index of the requester that owns the response; `ID_W = clog2(NUM_REQ)`.
- `busy`, output, 1: high in any state other than IDLE.

## Operation

- FSM states:
  - IDLE → CALC when any `req_valid` bit is high.
  - CALC → RESP when the cycle counter reaches `MULT_LAT-1`.
  - RESP → IDLE when `rsp_ready` is high.
- Arbitration in IDLE:
  - Round-robin search starting at `last_grant+1` (mod `NUM_REQ`).
  - The first requester found with `req_valid` high is granted, and `req_ready[grant]` is driven high combinationally in that same cycle.
  - The handshake completes when valid and ready are both high. On that edge the controller latches the requester's A, B and ID into the operand registers and sets `last_grant` to the grant index.
- The operand registers drive the multiplier inputs continuously. They do not change outside an IDLE handshake.
- CALC:
  - The counter counts from 0 to `MULT_LAT-1`.
  - On the final CALC edge, the multiplier output is captured into `rsp_z` and the latched ID into `rsp_id`.
- RESP:
  - `rsp_valid` is high; `rsp_z` and `rsp_id` are held stable until the handshake.
  - `req_ready` stays all-zero.
- Arithmetic: unsigned operands; the product is exact at `2*DATA_WIDTH` bits, so no overflow is possible.
- Non-granted requesters are not dropped; they keep `req_valid` asserted and wait for a later grant.
- A requester that deasserts `req_valid` before it is granted is simply skipped.
- Reset behaviour (synchronous, takes priority over everything):
  - State returns to IDLE; `last_grant` is set to `NUM_REQ-1`, so requester 0 has first priority.
  - Counter, operand registers, `rsp_z` and `rsp_id` are cleared to 0.
  - Outputs: `req_ready`=0, `rsp_valid`=0, `busy`=0.
  - A reset mid-operation (in CALC or RESP) discards the in-flight operation; no response is emitted afterwards.

## Timing

- Request accepted at cycle T:
  - CALC during T+1 … T+`MULT_LAT`.
  - `rsp_valid` rises at T+`MULT_LAT`+1.
- Response handshake in cycle R: the FSM is in IDLE at R+1, and the earliest next accept is at R+1.
- Peak throughput is one operation per `MULT_LAT`+2 cycles.
- Simultaneous requests: exactly one is granted per IDLE cycle; the others see `req_ready`=0.
- `rsp_ready` held high continuously: the RESP state lasts exactly 1 cycle.
- `rsp_ready` low: the controller stalls in RESP indefinitely, with no state or output change.
- Multicycle constraint: the path from operand registers to `rsp_z` may be constrained as a `MULT_LAT`-cycle path.

## Structure

- Shared header/package `mult_arb_pkg`:
  - FSM state encodings: IDLE=2'd0, CALC=2'd1, RESP=2'd2.
  - A `clog2` function used to derive `ID_W` and the counter width.
- Sub-module `mult_array` (the combinational `DATA_WIDTH`×`DATA_WIDTH` array multiplier), instantiated once.
- The round-robin priority search is a generate loop inside the controller, not a separate module.

## Test plan

- Single request: reset, then requester 2 sends A=15, B=15 with `MULT_LAT`=1 and `rsp_ready`=1 → accepted at T; `rsp_valid`=1 at T+2 with `rsp_z`=225, `rsp_id`=2; `busy` low from T+3.
- All four requesters valid continuously from reset, with A=i+1, B=3 → grants in order 0,1,2,3,0; responses 3,6,9,12 with IDs 0..3, spaced 3 cycles apart.
- Backpressure: `rsp_ready`=0 for 5 cycles during RESP → `rsp_z`/`rsp_id` stable, `req_ready` all-zero; the pending requester is granted the cycle after `rsp_ready` rises.
- `MULT_LAT`=3, A=9, B=7 → `rsp_valid` at T+4 with `rsp_z`=63; operand registers unchanged during the CALC cycles.
- Reset asserted in CALC → next cycle: state IDLE, `rsp_valid`=0, `busy`=0, and no response ever appears for that operation; a subsequent request from requester 1 is granted before one from requester 3.
- Edge operands: A=0, B=15 → 0; A=8, B=8 → 64; over 1000 random cycles, a scoreboard sees every accepted request return exactly once with the correct ID.
